tscache_param: RTL and testbench
================================

Name: tscache_param

Overview:
- Parametrised successor to the single-channel trigger-surround cache.
- Continuously buffers ADC samples in a circular RAM and detects a configurable threshold crossing (rising, falling, either edge or level).
- Freezes a window of PRE samples before the trigger, the trigger sample and the samples after it, timestamps the trigger, then reads the window out oldest-first over a req/rdy handshake.
- Sits between the ADC front end and the readout/host interface.

Parameters:
DATA_W, 8, ADC sample width in bits
ADDR_W, 4, buffer address width; DEPTH = 2**ADDR_W samples
PRE, 4, pre-trigger samples kept; legal range 1..DEPTH-2
TS_W, 32, timestamp counter width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  arm a new capture (honoured in IDLE only)
adc_data  in  DATA_W  sample value
adc_valid  in  1  adc_data valid this cycle
thresh  in  DATA_W  trigger threshold, unsigned
mode  in  2  00 rising, 01 falling, 10 either edge, 11 level (>=)
sbf  in  1  begin buffer readout (honoured in DONE only)
req  in  1  readout request; consumes dat when rdy=1
trd  out  1  trigger detected
cd  out  1  capture done
trigtm  out  TS_W  timestamp of the trigger sample
rdy  out  1  dat valid, request accepted
dat  out  DATA_W  readout sample
sd  out  1  send done, one-cycle pulse
current_state  out  3  FSM state code

Behaviour:
- Reset (any state, any cycle):
  - FSM goes to IDLE.
  - trd, cd, rdy and sd go to 0.
  - dat, trigtm and the timestamp counter go to 0.
  - All pointers and counters are cleared.
  - Buffer RAM contents are don't-care.
- Timestamp counter: free-running, increments every clk and wraps modulo 2**TS_W.
- FSM codes: IDLE=0, FILL=1, ARMED=2, POST=3, DONE=4, SEND=5.
- IDLE:
  - start=1 -> FILL; wr_ptr and fill count cleared; trd and cd cleared.
  - sbf, req and adc_valid are ignored.
- FILL:
  - Each adc_valid writes RAM[wr_ptr], increments wr_ptr and updates the prev register.
  - No trigger evaluation in FILL.
  - After PRE valid samples -> ARMED.
- ARMED: on adc_valid the sample is written at wr_ptr (wrapping modulo DEPTH) and the trigger is evaluated against prev:
  - rising: prev < thresh and cur >= thresh.
  - falling: prev >= thresh and cur < thresh.
  - either: rising or falling.
  - level: cur >= thresh.
  - On trigger: taddr = wr_ptr; trigtm = timestamp counter value that cycle; trd=1 from the next cycle; post count = DEPTH-PRE-1; go to POST.
  - The first ARMED sample uses the last FILL sample as prev.
- POST:
  - Each adc_valid writes the sample and decrements the post count.
  - When the last post sample is written -> DONE, with cd=1 from the next cycle.
  - Triggers are not re-evaluated.
- DONE:
  - trd and cd held at 1; adc_valid ignored.
  - sbf=1 -> SEND with rd_ptr = (taddr - PRE) mod DEPTH.
- SEND:
  - RAM read is registered: dat appears one cycle after rd_ptr is set, and rdy=1 when dat is valid.
  - req=1 with rdy=1 at a clock edge accepts the sample: rd_ptr increments, and rdy=0 for exactly one cycle while the next word is fetched.
  - req with rdy=0 is ignored.
  - After the DEPTH-th acceptance: rdy stays 0, sd pulses 1 for one cycle, then the FSM enters IDLE. trd and cd clear on the IDLE entry.
  - start is ignored in SEND.
- Readout order: PRE pre-trigger samples, then the trigger sample, then DEPTH-PRE-1 post samples.
- Changes to thresh and mode take effect on the next evaluated sample.
- Simultaneous reset with any other input: reset wins.

Test Plan:
1. Reset checks:
   - Assert reset 2 cycles with start=1 -> state=0; trd=cd=rdy=sd=0; dat=0; trigtm=0.
   - Reset applied with state=0, start=1, then released -> state=1 on the cycle after release.
2. Rising trigger:
   - Setup: DEPTH=16, PRE=4, thresh=0x08, mode=00, adc_valid every cycle, sample k = k from the cycle after start.
   - Trigger on sample 8; trigtm = counter at that cycle; cd after sample 19.
   - Readout after sbf gives 4,5,…,19 (16 words); sd pulses once; state returns to 0.
3. Falling trigger:
   - Setup: mode=01, samples 0x20 ×6 then 0x07, thresh=0x08.
   - No trigger on the initial 0x20s; trigger on the 0x07 sample.
   - Readout begins 0x20,0x20,0x20,0x20,0x07.
4. Wrap-around: 40 samples of value k (k=0..39) with thresh=0x30 (all below), then 0x30.
   - Readout = 36,37,38,39,0x30 followed by the post samples.
   - Proves the pointer wraps and only the last PRE samples are kept.
5. Abort and ignored inputs:
   - Reset asserted mid-POST -> state=0 and trd=0 next cycle.
   - sbf=1 in IDLE -> no state change.
   - req held high in DONE -> rdy stays 0.
6. Handshake:
   - req held continuously in SEND -> rdy alternates 1,0, giving one word per 2 cycles.
   - req pulsed while rdy=0 -> dat and rd_ptr unchanged.
   - sd pulses exactly one cycle after the 16th acceptance.

Source files
------------

// File: rtl/tscache_param.sv
// tscache_param: trigger-surround capture cache.
//
// Keeps writing ADC samples into a circular RAM. Once PRE samples are held,
// every valid sample is tested against a threshold crossing rule. On a hit the
// trigger address and timestamp are latched. Capture continues until the
// window of DEPTH samples around the trigger is complete. The window is then
// streamed out oldest-first over a req/rdy handshake.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             arm a capture (IDLE only)
//   adc_data/valid    incoming sample stream
//   thresh, mode      trigger threshold (unsigned) and rule:
//                     0 rising, 1 falling, 2 either edge, 3 level
//   sbf               begin readout (DONE only)
//   req               consume the current readout word when rdy=1
//   trd, cd           trigger detected / capture done
//   trigtm            timestamp of the trigger sample
//   rdy, dat          readout word valid / readout word
//   sd                one-cycle pulse after the last word is accepted
//   current_state     FSM code (IDLE=0 .. SEND=5)
module tscache_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int PRE    = 4,
  parameter int TS_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] thresh,
  input  logic [1:0]        mode,
  input  logic              sbf,
  input  logic              req,
  output logic              trd,
  output logic              cd,
  output logic [TS_W-1:0]   trigtm,
  output logic              rdy,
  output logic [DATA_W-1:0] dat,
  output logic              sd,
  output logic [2:0]        current_state
);

  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PRE_A   = ADDR_W'(PRE);
  localparam logic [ADDR_W-1:0] PRE_M1  = ADDR_W'(PRE - 1);
  localparam logic [ADDR_W-1:0] POST_N  = ADDR_W'(DEPTH - PRE - 1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   DEPTH_N = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LAST_N  = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4,
    SEND  = 3'd5
  } state_t;

  state_t            state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [TS_W-1:0]   ts_cnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] taddr;
  logic [ADDR_W-1:0] fill_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W:0]   acc_cnt;
  logic [DATA_W-1:0] prev_p0;
  logic [DATA_W-1:0] dat_p1;
  logic              vld_p1;

  logic              wr_en;
  logic              trig_fire;
  logic              post_last;
  logic              accept;
  logic              fetch;
  logic              send_end;

  function automatic logic trig_hit(
    input logic [DATA_W-1:0] p,
    input logic [DATA_W-1:0] c,
    input logic [DATA_W-1:0] th,
    input logic [1:0]        m
  );
    logic rise;
    logic fall;
    rise = (p < th) && (c >= th);
    fall = (p >= th) && (c < th);
    case (m)
      2'b00:   trig_hit = rise;
      2'b01:   trig_hit = fall;
      2'b10:   trig_hit = rise | fall;
      default: trig_hit = (c >= th);
    endcase
  endfunction

  assign wr_en     = adc_valid && ((state == FILL) || (state == ARMED) || (state == POST));
  assign trig_fire = (state == ARMED) && adc_valid && trig_hit(prev_p0, adc_data, thresh, mode);
  assign post_last = (state == POST) && adc_valid && (post_cnt == ONE_A);
  assign accept    = (state == SEND) && vld_p1 && req;
  // acc_cnt reaching DEPTH marks the sd cycle; nothing more is fetched after it.
  assign send_end  = (state == SEND) && (acc_cnt == DEPTH_N);
  assign fetch     = (state == SEND) && !vld_p1 && !send_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (adc_valid && (fill_cnt == PRE_M1)) state_nxt = ARMED;
      ARMED:   if (trig_fire) state_nxt = POST;
      POST:    if (post_last) state_nxt = DONE;
      DONE:    if (sbf) state_nxt = SEND;
      SEND:    if (send_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: sample write into the circular buffer
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= adc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      taddr    <= '0;
      fill_cnt <= '0;
      post_cnt <= '0;
      acc_cnt  <= '0;
      prev_p0  <= '0;
      trigtm   <= '0;
      trd      <= 1'b0;
      cd       <= 1'b0;
      sd       <= 1'b0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      sd     <= 1'b0;

      if ((state == IDLE) && start) begin
        wr_ptr   <= '0;
        fill_cnt <= '0;
        trd      <= 1'b0;
        cd       <= 1'b0;
      end

      if (wr_en) begin
        wr_ptr  <= wr_ptr + 1'b1;
        prev_p0 <= adc_data;
      end

      if ((state == FILL) && adc_valid) begin
        fill_cnt <= fill_cnt + 1'b1;
      end

      if (trig_fire) begin
        taddr    <= wr_ptr;
        trigtm   <= ts_cnt;
        trd      <= 1'b1;
        post_cnt <= POST_N;
      end

      if ((state == POST) && adc_valid) begin
        post_cnt <= post_cnt - 1'b1;
        if (post_last) begin
          cd <= 1'b1;
        end
      end

      if ((state == DONE) && sbf) begin
        rd_ptr  <= taddr - PRE_A;
        acc_cnt <= '0;
      end

      if (accept) begin
        rd_ptr  <= rd_ptr + 1'b1;
        acc_cnt <= acc_cnt + 1'b1;
        sd      <= (acc_cnt == LAST_N);
      end

      if (send_end) begin
        trd <= 1'b0;
        cd  <= 1'b0;
      end
    end
  end

  // Stage p1: registered RAM read; vld_p1 drops for one cycle after each accept
  always_ff @(posedge clk) begin
    if (reset) begin
      dat_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      if (fetch) begin
        dat_p1 <= mem[rd_ptr];
        vld_p1 <= 1'b1;
      end else if (accept || (state != SEND)) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign rdy           = vld_p1;
  assign dat           = dat_p1;
  assign current_state = state;

endmodule

// File: tb/tb_tscache_param.sv
// tb_tscache_param: directed plus randomized bench for tscache_param.
//
// A reference model keeps every valid sample of a capture in a queue.
// It locates the trigger by applying the crossing rule to consecutive samples.
// The expected readout window is the DEPTH samples starting PRE before the
// trigger sample.
module tb_tscache_param;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int PRE    = 4;
  localparam int TS_W   = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              adc_valid = 1'b0;
  logic [DATA_W-1:0] thresh = '0;
  logic [1:0]        mode = 2'b00;
  logic              sbf = 1'b0;
  logic              req = 1'b0;
  logic              trd;
  logic              cd;
  logic [TS_W-1:0]   trigtm;
  logic              rdy;
  logic [DATA_W-1:0] dat;
  logic              sd;
  logic [2:0]        current_state;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] ts_m = 32'd0;
  logic [7:0]  hist[$];
  logic [7:0]  dir_q[$];
  int          trig_idx = -1;
  logic [31:0] exp_tm = 32'd0;
  bit          cap_done = 1'b0;

  tscache_param #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .PRE   (PRE),
    .TS_W  (TS_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .thresh       (thresh),
    .mode         (mode),
    .sbf          (sbf),
    .req          (req),
    .trd          (trd),
    .cd           (cd),
    .trigtm       (trigtm),
    .rdy          (rdy),
    .dat          (dat),
    .sd           (sd),
    .current_state(current_state)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock; the model timestamp follows the free-running counter.
  task automatic tick();
    @(posedge clk);
    if (reset) ts_m = 32'd0;
    else       ts_m = ts_m + 32'd1;
    #1;
  endtask

  function automatic bit model_hit(input logic [7:0] p, input logic [7:0] c,
                                   input logic [1:0] m, input logic [7:0] th);
    bit rise;
    bit fall;
    rise = (p < th) && (c >= th);
    fall = (p >= th) && (c < th);
    case (m)
      2'b00:   return rise;
      2'b01:   return fall;
      2'b10:   return rise || fall;
      default: return c >= th;
    endcase
  endfunction

  task automatic push_sample(input logic [7:0] v);
    int idx;
    adc_data  = v;
    adc_valid = 1'b1;
    hist.push_back(v);
    idx = hist.size() - 1;
    if ((trig_idx < 0) && (idx >= PRE) && model_hit(hist[idx-1], v, mode, thresh)) begin
      trig_idx = idx;
      exp_tm   = ts_m;
    end
    tick();
    adc_valid = 1'b0;
    cap_done  = (trig_idx >= 0) && (hist.size() == trig_idx + DEPTH - PRE);
    check("trd_track", 64'(trd), 64'(trig_idx >= 0));
    check("cd_track", 64'(cd), 64'(cap_done));
  endtask

  task automatic begin_capture(input logic [1:0] m, input logic [7:0] th);
    mode     = m;
    thresh   = th;
    hist.delete();
    trig_idx = -1;
    cap_done = 1'b0;
    exp_tm   = 32'd0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    check("fill_entry", 64'(current_state), 64'(1));
  endtask

  task automatic capture(input logic [1:0] m, input logic [7:0] th, input bit gaps);
    int         n;
    logic [7:0] v;
    begin_capture(m, th);
    n = 0;
    while (!cap_done && (n < 200)) begin
      if (dir_q.size() > 0)
        v = dir_q.pop_front();
      else if (hist.size() > PRE + 40)
        v = (hist[hist.size()-1] == 8'h00) ? 8'hFF : 8'h00;
      else
        v = 8'($urandom);
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        adc_data  = 8'($urandom);
        adc_valid = 1'b0;
        tick();
      end
      push_sample(v);
      n++;
    end
    check("capture_complete", 64'(cap_done), 64'(1));
    check("done_state", 64'(current_state), 64'(4));
    check("done_trd", 64'(trd), 64'(1));
    check("done_cd", 64'(cd), 64'(1));
    check("trigtm", 64'(trigtm), 64'(exp_tm));
  endtask

  task automatic readout(input bit hold);
    logic [7:0] w;
    if (!cap_done) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
      return;
    end
    sbf = 1'b1;
    tick();
    sbf = 1'b0;
    check("send_entry", 64'(current_state), 64'(5));
    check("rdy_before_fetch", 64'(rdy), 64'(0));
    if (hold) req = 1'b1;
    tick();
    for (int j = 0; j < DEPTH; j++) begin
      w = hist[trig_idx - PRE + j];
      if (!hold) repeat ($urandom_range(0, 2)) tick();
      check("rdy_word", 64'(rdy), 64'(1));
      check("dat_word", 64'(dat), 64'(w));
      req = 1'b1;
      tick();
      check("rdy_after_accept", 64'(rdy), 64'(0));
      check("sd_pulse", 64'(sd), 64'(j == DEPTH - 1));
      if (!hold) req = 1'($urandom_range(0, 1));
      if (j < DEPTH - 1) tick();
      if (!hold) req = 1'b0;
    end
    check("sd_cycle_state", 64'(current_state), 64'(5));
    tick();
    req = 1'b0;
    check("sd_clear", 64'(sd), 64'(0));
    check("idle_after_send", 64'(current_state), 64'(0));
    check("trd_clear", 64'(trd), 64'(0));
    check("cd_clear", 64'(cd), 64'(0));
    check("rdy_idle", 64'(rdy), 64'(0));
  endtask

  initial begin
    // Reset held with start asserted
    reset = 1'b1;
    start = 1'b1;
    tick();
    tick();
    check("rst_state", 64'(current_state), 64'(0));
    check("rst_trd", 64'(trd), 64'(0));
    check("rst_cd", 64'(cd), 64'(0));
    check("rst_rdy", 64'(rdy), 64'(0));
    check("rst_sd", 64'(sd), 64'(0));
    check("rst_dat", 64'(dat), 64'(0));
    check("rst_trigtm", 64'(trigtm), 64'(0));
    reset = 1'b0;
    tick();
    check("start_after_reset", 64'(current_state), 64'(1));
    start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_again", 64'(current_state), 64'(0));

    // Rising edge, sample k = k
    for (int k = 0; k < 20; k++) dir_q.push_back(8'(k));
    capture(2'b00, 8'h08, 1'b0);
    readout(1'b0);

    // Falling edge after a run of high samples
    repeat (6) dir_q.push_back(8'h20);
    dir_q.push_back(8'h07);
    capture(2'b01, 8'h08, 1'b0);
    readout(1'b0);

    // Pointer wrap: 40 below-threshold samples, then the crossing
    for (int k = 0; k < 40; k++) dir_q.push_back(8'(k));
    dir_q.push_back(8'h30);
    capture(2'b00, 8'h30, 1'b0);
    readout(1'b0);

    // Reset in the middle of POST
    begin_capture(2'b00, 8'h08);
    for (int k = 0; k < 10; k++) push_sample(8'(k));
    check("post_state", 64'(current_state), 64'(3));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_state", 64'(current_state), 64'(0));
    check("abort_trd", 64'(trd), 64'(0));

    // sbf ignored in IDLE
    sbf = 1'b1;
    tick();
    sbf = 1'b0;
    check("sbf_idle_state", 64'(current_state), 64'(0));

    // req ignored in DONE, then readout with req held continuously
    capture(2'b10, 8'($urandom_range(1, 255)), 1'b1);
    req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("done_req_rdy", 64'(rdy), 64'(0));
      check("done_req_state", 64'(current_state), 64'(4));
    end
    req = 1'b0;
    readout(1'b1);

    // Randomized captures
    for (int r = 0; r < 6; r++) begin
      capture(2'($urandom_range(0, 3)), 8'($urandom_range(1, 255)), 1'b1);
      readout(1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
